add_32_result_stage: RTL and testbench

Downstream result stage for the two-stage pipelined 32-bit adder. It tracks each operation issued into the adder through a fixed-latency valid/tag pipeline. At maturity it captures `add_sum`/`add_cout` and derives zero and signed-overflow flags. Results are buffered in a small FIFO and presented to writeback over a valid/ready handshake. The adder cannot stall, so the block applies credit-based backpressure on the issue side.

---
 rtl/add_32_result_stage.sv | 148 ++++++++++++++
 tb/tb_add_32_result_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_32_result_stage.sv
// Result stage behind the two-stage 32-bit adder: tracks issued ops through a
// fixed-latency tag pipe, captures sum/carry with zero and overflow flags into
// a small FIFO, and hands results to writeback with credit-based issue control.
`timescale 1ns/1ps
module add_32_result_stage #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             issue_a_msb,
    input  logic             issue_b_msb,
    input  logic [31:0]      add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    // tracking pipe
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_amsb;
    logic [LATENCY-1:0] r_bmsb;
    logic [TAG_W-1:0]   r_tag [LATENCY];

    // result FIFO
    logic [31:0]        r_mem_sum  [DEPTH];
    logic               r_mem_cout [DEPTH];
    logic               r_mem_zero [DEPTH];
    logic               r_mem_ovf  [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag  [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_inflight;

    logic               w_ready;
    logic               w_accept;
    logic               w_capture;
    logic               w_out_valid;
    logic               w_pop;
    logic               w_zero;
    logic               w_ovf;

    // Credit check uses registered occupancy only, so no path from issue_valid/out_ready.
    assign w_ready     = reset & ((SUM_W'(r_count) + SUM_W'(r_inflight)) < SUM_W'(DEPTH));
    assign w_accept    = issue_valid & w_ready;
    assign w_capture   = r_vld[LATENCY-1];
    assign w_out_valid = reset & (r_count != '0);
    assign w_pop       = w_out_valid & out_ready;
    assign w_zero      = (add_sum == 32'd0);
    assign w_ovf       = (r_amsb[LATENCY-1] == r_bmsb[LATENCY-1]) &
                         (add_sum[31] != r_amsb[LATENCY-1]);

    // Shift accepted ops (and bubbles) toward the capture point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld  <= '0;
            r_amsb <= '0;
            r_bmsb <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_vld[0]  <= w_accept;
            r_amsb[0] <= issue_a_msb;
            r_bmsb[0] <= issue_b_msb;
            r_tag[0]  <= issue_tag;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_amsb[i] <= r_amsb[i-1];
                r_bmsb[i] <= r_bmsb[i-1];
                r_tag[i]  <= r_tag[i-1];
            end
        end
    end

    // Write the matured result into the FIFO slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem_sum[r_wptr]  <= add_sum;
            r_mem_cout[r_wptr] <= add_cout;
            r_mem_zero[r_wptr] <= w_zero;
            r_mem_ovf[r_wptr]  <= w_ovf;
            r_mem_tag[r_wptr]  <= r_tag[LATENCY-1];
        end
    end

    // Pointers, occupancy and in-flight credit counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_capture) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_capture && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_capture && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_accept && !w_capture) begin
                r_inflight <= r_inflight + CNT_W'(1);
            end else if (!w_accept && w_capture) begin
                r_inflight <= r_inflight - CNT_W'(1);
            end
        end
    end

    // Head of FIFO straight from storage; everything forced low during reset.
    always_comb begin
        issue_ready = w_ready;
        out_valid   = w_out_valid;
        out_sum     = 32'd0;
        out_cout    = 1'b0;
        out_zero    = 1'b0;
        out_ovf     = 1'b0;
        out_tag     = '0;
        busy        = reset & ((r_inflight != '0) | (r_count != '0));
        if (reset) begin
            out_sum  = r_mem_sum[r_rptr];
            out_cout = r_mem_cout[r_rptr];
            out_zero = r_mem_zero[r_rptr];
            out_ovf  = r_mem_ovf[r_rptr];
            out_tag  = r_mem_tag[r_rptr];
        end
    end

endmodule

// File: tb/tb_add_32_result_stage.sv
// Directed bench for add_32_result_stage with a queue-based reference model
// and a behavioural stand-in for the pipelined adder.
`timescale 1ns/1ps
module tb_add_32_result_stage;

    localparam int unsigned LATENCY = 2;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned TAG_W   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             iv = 1'b0;
    logic             ordy = 1'b0;
    logic [TAG_W-1:0] itag = '0;
    logic [31:0]      ia = '0;
    logic [31:0]      ib = '0;

    logic             issue_ready;
    logic [31:0]      add_sum;
    logic             add_cout;
    logic             out_valid;
    logic [31:0]      out_sum;
    logic             out_cout;
    logic             out_zero;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    add_32_result_stage #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (iv),
        .issue_ready (issue_ready),
        .issue_tag   (itag),
        .issue_a_msb (ia[31]),
        .issue_b_msb (ib[31]),
        .add_sum     (add_sum),
        .add_cout    (add_cout),
        .out_valid   (out_valid),
        .out_ready   (ordy),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .out_zero    (out_zero),
        .out_ovf     (out_ovf),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    // Adder stand-in: operands of the cycle ending at E appear LATENCY edges later; never reset.
    logic [32:0] r_pipe [LATENCY];
    always_ff @(posedge clk) begin
        r_pipe[0] <= {1'b0, ia} + {1'b0, ib};
        for (int i = 1; i < int'(LATENCY); i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign add_sum  = r_pipe[LATENCY-1][31:0];
    assign add_cout = r_pipe[LATENCY-1][32];

    // Reference model
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      a;
        logic [31:0]      b;
        int               due;
    } op_t;
    typedef struct {
        logic [31:0]      sum;
        logic             cout;
        logic             zero;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } res_t;

    op_t  q_fl[$];
    res_t q_ff[$];
    int   cyc = 0;
    bit   last_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t model_result(input op_t o);
        res_t   r;
        longint sa, sb, ss;
        logic [32:0] u;
        u  = {1'b0, o.a} + {1'b0, o.b};
        sa = longint'($signed(o.a));
        sb = longint'($signed(o.b));
        ss = sa + sb;
        r.sum  = u[31:0];
        r.cout = u[32];
        r.zero = (u[31:0] == 32'd0);
        r.ovf  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        r.tag  = o.tag;
        return r;
    endfunction

    function automatic bit model_ready();
        return (q_ff.size() + q_fl.size()) < DEPTH;
    endfunction

    task automatic compare_all();
        chk("issue_ready", 64'(issue_ready), 64'(model_ready()));
        chk("out_valid", 64'(out_valid), 64'(q_ff.size() != 0));
        chk("busy", 64'(busy), 64'((q_ff.size() + q_fl.size()) != 0));
        if (q_ff.size() != 0) begin
            chk("out_sum", 64'(out_sum), 64'(q_ff[0].sum));
            chk("out_cout", 64'(out_cout), 64'(q_ff[0].cout));
            chk("out_zero", 64'(out_zero), 64'(q_ff[0].zero));
            chk("out_ovf", 64'(out_ovf), 64'(q_ff[0].ovf));
            chk("out_tag", 64'(out_tag), 64'(q_ff[0].tag));
        end
    endtask

    // One clock: decide handshakes from the model, advance model at the edge, compare 1ns later.
    task automatic step();
        bit   acc, pop;
        op_t  o;
        res_t r;
        acc = iv && model_ready();
        pop = (q_ff.size() != 0) && ordy;
        @(posedge clk);
        cyc++;
        if (pop) void'(q_ff.pop_front());
        if (q_fl.size() != 0 && q_fl[0].due == cyc) begin
            o = q_fl.pop_front();
            r = model_result(o);
            if (q_ff.size() >= DEPTH) begin
                n_cmp++; n_err++;
                $display("FAIL push_full: capture with FIFO holding %0d, limit %0d", q_ff.size(), DEPTH);
            end
            q_ff.push_back(r);
        end
        if (acc) q_fl.push_back('{tag: itag, a: ia, b: ib, due: cyc + int'(LATENCY)});
        last_acc = acc;
        #1;
        compare_all();
    endtask

    task automatic issue_one(input logic [TAG_W-1:0] t, input logic [31:0] a, input logic [31:0] b);
        int n;
        iv = 1'b1; itag = t; ia = a; ib = b;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        chk("issue_accept", 64'(last_acc), 64'd1);
        iv = 1'b0; ia = '0; ib = '0;
    endtask

    task automatic check_all_zero(input string tagname);
        chk({tagname, "_ir"}, 64'(issue_ready), 64'd0);
        chk({tagname, "_ov"}, 64'(out_valid), 64'd0);
        chk({tagname, "_sum"}, 64'(out_sum), 64'd0);
        chk({tagname, "_cout"}, 64'(out_cout), 64'd0);
        chk({tagname, "_zero"}, 64'(out_zero), 64'd0);
        chk({tagname, "_ovf"}, 64'(out_ovf), 64'd0);
        chk({tagname, "_tag"}, 64'(out_tag), 64'd0);
        chk({tagname, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int w;
        // power-on reset
        #12;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("por_release_ir", 64'(issue_ready), 64'd1);
        chk("por_release_ov", 64'(out_valid), 64'd0);

        // single issue: 1 + 0xFFFFFFFF, valid LATENCY edges after accept
        ordy = 1'b0;
        issue_one(5'd3, 32'h0000_0001, 32'hFFFF_FFFF);
        chk("t1_lat_e0", 64'(out_valid), 64'd0);
        step();
        chk("t1_lat_e1", 64'(out_valid), 64'd0);
        step();
        chk("t1_lat_e2", 64'(out_valid), 64'd1);
        chk("t1_sum", 64'(out_sum), 64'h0);
        chk("t1_cout", 64'(out_cout), 64'd1);
        chk("t1_zero", 64'(out_zero), 64'd1);
        chk("t1_ovf", 64'(out_ovf), 64'd0);
        chk("t1_tag", 64'(out_tag), 64'd3);
        ordy = 1'b1;
        step();
        chk("t1_busy_after_pop", 64'(busy), 64'd0);

        // signed overflow
        ordy = 1'b0;
        issue_one(5'd4, 32'h7FFF_FFFF, 32'h0000_0001);
        w = 0;
        while (!out_valid && w < 10) begin step(); w++; end
        chk("t2_arrive", 64'(out_valid), 64'd1);
        chk("t2_sum", 64'(out_sum), 64'h8000_0000);
        chk("t2_ovf", 64'(out_ovf), 64'd1);
        chk("t2_zero", 64'(out_zero), 64'd0);
        chk("t2_cout", 64'(out_cout), 64'd0);
        ordy = 1'b1;
        step();

        // backpressure: two accepts fill the credits, tag 3 waits
        ordy = 1'b0;
        issue_one(5'd1, 32'h0000_0010, 32'h0000_0020);
        issue_one(5'd2, 32'h8000_0000, 32'h8000_0000);
        chk("bp_ready_low", 64'(issue_ready), 64'd0);
        iv = 1'b1; itag = 5'd3; ia = 32'h0000_0003; ib = 32'h0000_0004;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_ready_held", 64'(issue_ready), 64'd0);
        end
        chk("bp_head1", 64'(out_tag), 64'd1);
        ordy = 1'b1;
        step();
        chk("bp_ready_after_pop", 64'(issue_ready), 64'd1);
        chk("bp_head2", 64'(out_tag), 64'd2);
        chk("bp_head2_ovf", 64'(out_ovf), 64'd1);
        step();
        chk("bp_tag3_accepted", 64'(last_acc), 64'd1);
        iv = 1'b0; ia = '0; ib = '0;
        repeat (4) step();

        // simultaneous capture and pop with one entry buffered
        issue_one(5'd10, 32'h0000_0005, 32'h0000_0006);
        issue_one(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        chk("sim_head_a", 64'(out_tag), 64'd10);
        step();
        chk("sim_still_valid", 64'(out_valid), 64'd1);
        chk("sim_head_b", 64'(out_tag), 64'd11);
        chk("sim_head_b_sum", 64'(out_sum), 64'hFFFF_FFFE);
        step();
        chk("sim_empty", 64'(out_valid), 64'd0);

        // streaming with random gaps
        ordy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 2)) step();
            issue_one(TAG_W'(k + 12), $urandom, $urandom);
        end
        repeat (8) step();
        chk("stream_drained_busy", 64'(busy), 64'd0);

        // reset with one in flight and one buffered
        ordy = 1'b0;
        issue_one(5'd20, 32'h1234_5678, 32'h1111_1111);
        repeat (2) step();
        issue_one(5'd21, 32'h0000_0000, 32'h0000_0000);
        chk("mid_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        q_fl.delete();
        q_ff.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_ov", 64'(out_valid), 64'd0);
            chk("post_rst_ir", 64'(issue_ready), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
